// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB definitions for the slave multiplexer:
//   - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - HRESP encodings (OKAY, ERROR)
//   - default-slave state enum (IDLE, ERR1, ERR2)
//   - is_active(): true for transfer types that need a response
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY get a zero-wait OKAY.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ----------------------------------------------------------------------------
// ahb_default_slave
// Responds when no real slave owns the data phase. An active transfer to an
// unmapped address gets the two-cycle AHB ERROR response; everything else gets
// a zero-wait OKAY.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   hready_i    bus HREADY (address phase is sampled when high)
//   unmapped_i  address phase has no HSEL set and an active HTRANS
//   timeout_i   watchdog abort of a stalled slave: force an ERROR
//   hready_o    default-slave HREADY contribution
//   hresp_o     default-slave HRESP contribution
//   state_o     current FSM state (observation)
//
// Handshake: an address phase is accepted only on an edge where hready_i=1;
// ERR1 drives hready_o=0 so the following ERR2 cycle is the completing edge.
// ----------------------------------------------------------------------------
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      hready_i,
    input  logic      unmapped_i,
    input  logic      timeout_i,
    output logic      hready_o,
    output logic      hresp_o,
    output ds_state_e state_o
);

    ds_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (timeout_i || (hready_i && unmapped_i)) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                // Address phase inputs are not sampled here: HREADY is low.
                hready_o = 1'b0;
                hresp_o  = HRESP_ERROR;
                state_d  = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_o = HRESP_ERROR;
                // ERR2 completes with HREADY=1, so a fresh unmapped transfer
                // is accepted here and starts the next error immediately.
                if (hready_i && unmapped_i) begin
                    state_d = DS_ERR1;
                end else begin
                    state_d = DS_IDLE;
                end
            end
            default: state_d = DS_IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// ahb_slave_mux
// AHB data-phase multiplexer. HSEL is captured (lowest index wins) whenever
// HREADY is high; the captured select routes the chosen slave's HRDATA,
// HREADYOUT and HRESP back to the master with no added latency. With no slave
// selected, the internal ahb_default_slave answers.
//
// Parameters: NSLAVE (1..16), DW (data width), TMO_CYCLES (watchdog limit).
//
// Ports:
//   HCLK, HRESETn   clock, synchronous active-low reset
//   HSEL[NSLAVE]    address-phase slave selects
//   HTRANS[2]       address-phase transfer type
//   HRDATA_S        slave read data, slave i at [i*DW +: DW]
//   HREADYOUT_S     per-slave ready
//   HRESP_S         per-slave response (1 = ERROR)
//   HRDATA          muxed read data
//   HREADY          bus ready (also samples the address phase here)
//   HRESP           muxed response
//
// Optional feature: define AHB_MUX_TIMEOUT_EN to add a watchdog that aborts a
// slave holding HREADYOUT low for TMO_CYCLES cycles with an ERROR response.
// ----------------------------------------------------------------------------
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int NSLAVE     = 4,
    parameter int DW         = 32,
    parameter int TMO_CYCLES = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NSLAVE-1:0]    HSEL,
    input  logic [1:0]           HTRANS,
    input  logic [NSLAVE*DW-1:0] HRDATA_S,
    input  logic [NSLAVE-1:0]    HREADYOUT_S,
    input  logic [NSLAVE-1:0]    HRESP_S,
    output logic [DW-1:0]        HRDATA,
    output logic                 HREADY,
    output logic                 HRESP
);

    if (NSLAVE < 1 || NSLAVE > 16 || TMO_CYCLES < 1) begin : g_bad_param
        $error("ahb_slave_mux: parameter out of range");
    end

    logic [NSLAVE-1:0] sel_q, sel_d;
    logic [NSLAVE-1:0] hsel_pri;
    logic              unmapped;
    logic              timeout;
    logic              ds_hready;
    logic              ds_hresp;
    ds_state_e         ds_state;

    // x & -x isolates the lowest set bit: lowest index wins.
    assign hsel_pri = HSEL & (~HSEL + NSLAVE'(1));
    assign unmapped = (HSEL == '0) && is_active(HTRANS);

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    assign stall = (sel_q != '0) && !HREADY;

    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (stall) begin
            if (cnt_q == CNT_W'(TMO_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A timeout drops the stalled slave so its late outputs are ignored.
    always_comb begin
        sel_d = sel_q;
        if (timeout) begin
            sel_d = '0;
        end else if (HREADY) begin
            sel_d = hsel_pri;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    ahb_default_slave u_default (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .hready_i   (HREADY),
        .unmapped_i (unmapped),
        .timeout_i  (timeout),
        .hready_o   (ds_hready),
        .hresp_o    (ds_hresp),
        .state_o    (ds_state)
    );

    always_comb begin
        HRDATA = '0;
        HREADY = ds_hready;
        HRESP  = ds_hresp;
        if (sel_q != '0) begin
            HREADY = 1'b0;
            HRESP  = HRESP_OKAY;
            for (int i = 0; i < NSLAVE; i++) begin
                if (sel_q[i]) begin
                    HRDATA = HRDATA_S[i*DW +: DW];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                end
            end
        end
    end

    // A real slave is only ever captured on an edge that leaves the default
    // slave idle, so the two sources never compete.
    a_sel_implies_idle : assert property (
        @(posedge HCLK) disable iff (!HRESETn)
        (sel_q != '0) |-> (ds_state == DS_IDLE)
    );

endmodule

// File: tb/tb_ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_mux
// Directed bench for ahb_slave_mux (NSLAVE=4, DW=32, TMO_CYCLES=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Each check compares {HRDATA, HREADY, HRESP}.
// ----------------------------------------------------------------------------
module tb_ahb_slave_mux;
    import ahb_pkg::*;

    localparam int NSLAVE = 4;
    localparam int DW     = 32;
    localparam int TMO    = 8;

    localparam logic [DW-1:0] D0 = 32'h1111_1111;
    localparam logic [DW-1:0] D1 = 32'hCAFE_F00D;
    localparam logic [DW-1:0] D2 = 32'h2222_2222;
    localparam logic [DW-1:0] D3 = 32'h3333_3333;

    logic                 HCLK = 1'b0;
    logic                 HRESETn;
    logic [NSLAVE-1:0]    HSEL;
    logic [1:0]           HTRANS;
    logic [NSLAVE*DW-1:0] HRDATA_S;
    logic [NSLAVE-1:0]    HREADYOUT_S;
    logic [NSLAVE-1:0]    HRESP_S;
    logic [DW-1:0]        HRDATA;
    logic                 HREADY;
    logic                 HRESP;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW+1:0] got_v, exp_v;

    always #5 HCLK = ~HCLK;

    ahb_slave_mux #(.NSLAVE(NSLAVE), .DW(DW), .TMO_CYCLES(TMO)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HSEL   = '0;
        HTRANS = HTRANS_IDLE;
    endtask

    task automatic test_reset();
        HRESETn     = 1'b0;
        idle_bus();
        HRDATA_S    = {D3, D2, D1, D0};
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        step();
        step();
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL reset_state: got %h expected %h", got_v, exp_v); else pass_cnt++;
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_basic_read();
        HSEL = 4'b0010; HTRANS = HTRANS_NONSEQ;
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL basic_addr_phase: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        idle_bus();
        exp_v = {D1, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL basic_data_phase: got %h expected %h", got_v, exp_v); else pass_cnt++;
        // Slave response reaches HRESP in the same cycle.
        HRESP_S[1] = 1'b1;
        #1;
        exp_v = {D1, 1'b1, 1'b1};
        got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL basic_comb_resp: got %h expected %h", got_v, exp_v); else pass_cnt++;
        HRESP_S[1] = 1'b0;
        step();
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL basic_idle_okay: got %h expected %h", got_v, exp_v); else pass_cnt++;
    endtask

    task automatic test_priority();
        HSEL = 4'b0110; HTRANS = HTRANS_NONSEQ;
        step();
        idle_bus();
        exp_v = {D1, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL priority_low_wins: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL priority_after: got %h expected %h", got_v, exp_v); else pass_cnt++;
    endtask

    task automatic test_unmapped();
        HSEL = '0; HTRANS = HTRANS_NONSEQ;
        step();
        // ERR1; master keeps presenting another unmapped NONSEQ.
        exp_v = {32'h0, 1'b0, 1'b1};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL unmapped_err1: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        exp_v = {32'h0, 1'b1, 1'b1};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL unmapped_err2: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        idle_bus();
        exp_v = {32'h0, 1'b0, 1'b1};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL b2b_err1: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        exp_v = {32'h0, 1'b1, 1'b1};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL b2b_err2: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL unmapped_back_idle: got %h expected %h", got_v, exp_v); else pass_cnt++;
    endtask

    task automatic test_stall();
        HSEL = 4'b0001; HTRANS = HTRANS_NONSEQ;
        step();
        HREADYOUT_S[0] = 1'b0;
        HSEL = 4'b0100; HTRANS = HTRANS_NONSEQ;
        for (int k = 0; k < 3; k++) begin
            exp_v = {D0, 1'b0, 1'b0};
            @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
            if (got_v !== exp_v) $display("FAIL stall_cycle%0d: got %h expected %h", k, got_v, exp_v); else pass_cnt++;
            step();
        end
        HREADYOUT_S[0] = 1'b1;
        exp_v = {D0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL stall_release: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        idle_bus();
        exp_v = {D2, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL stall_next_slave: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_in_err1();
        HSEL = '0; HTRANS = HTRANS_NONSEQ;
        step();
        exp_v = {32'h0, 1'b0, 1'b1};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL rst_err1_before: got %h expected %h", got_v, exp_v); else pass_cnt++;
        HRESETn = 1'b0;
        idle_bus();
        step();
        HRESETn = 1'b1;
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL rst_err1_after: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        HSEL = 4'b0001; HTRANS = HTRANS_NONSEQ;
        step();
        HSEL = 4'b0100; HTRANS = HTRANS_SEQ;
        exp_v = {D0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL b2b_slave0: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        HSEL = 4'b1000; HTRANS = HTRANS_NONSEQ;
        exp_v = {D2, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL b2b_slave2: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        idle_bus();
        exp_v = {D3, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL b2b_slave3: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL b2b_end_idle: got %h expected %h", got_v, exp_v); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int bad;
        HSEL = 4'b1000; HTRANS = HTRANS_NONSEQ;
        step();
        HREADYOUT_S[3] = 1'b0;
        idle_bus();
`ifdef AHB_MUX_TIMEOUT_EN
        bad = 0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge HCLK);
            if ({HRDATA, HREADY, HRESP} !== {D3, 1'b0, 1'b0}) bad++;
            step();
        end
        total_cnt++;
        if (bad != 0) $display("FAIL tmo_stall_window: got %0d bad cycles expected 0", bad); else pass_cnt++;
        exp_v = {32'h0, 1'b0, 1'b1};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL tmo_err1: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        exp_v = {32'h0, 1'b1, 1'b1};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL tmo_err2: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        // Slave 3 is still not ready but no longer owns the bus.
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL tmo_ignored_after: got %h expected %h", got_v, exp_v); else pass_cnt++;
        HREADYOUT_S[3] = 1'b1;
        step();
`else
        bad = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge HCLK);
            if ({HRDATA, HREADY, HRESP} !== {D3, 1'b0, 1'b0}) bad++;
            step();
        end
        total_cnt++;
        if (bad != 0) $display("FAIL stall_persists: got %0d bad cycles expected 0", bad); else pass_cnt++;
        HREADYOUT_S[3] = 1'b1;
        exp_v = {D3, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL stall_released: got %h expected %h", got_v, exp_v); else pass_cnt++;
        step();
        exp_v = {32'h0, 1'b1, 1'b0};
        @(negedge HCLK); got_v = {HRDATA, HREADY, HRESP}; total_cnt++;
        if (got_v !== exp_v) $display("FAIL stall_end_idle: got %h expected %h", got_v, exp_v); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_priority();
        test_unmapped();
        test_stall();
        test_reset_in_err1();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Safety net: the bench must always end on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/ahb_slave_mux.md
AHB_SLAVE_MUX -- requirements
Module: ahb_slave_mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; parameters SHALL be as follows:
- NSLAVE, 4, number of slave ports, range 1..16.
- DW, 32, data width.
- TMO_CYCLES, 256, watchdog limit; used only with AHB_MUX_TIMEOUT_EN.

REQ-002 Ports SHALL be as follows:
- HCLK  in  1  clock.
- HRESETn  in  1  synchronous, active-low reset.
- HSEL  in  NSLAVE  address-phase slave selects.
- HTRANS  in  2  address-phase transfer type.
- HRDATA_S  in  NSLAVE*DW  slave read data; slave i at [i*DW +: DW].
- HREADYOUT_S  in  NSLAVE  per-slave ready.
- HRESP_S  in  NSLAVE  per-slave response (1 = ERROR).
- HRDATA  out  DW  muxed read data.
- HREADY  out  1  bus ready; also used internally.
- HRESP  out  1  muxed response.

Function
REQ-003 The select register SHALL capture the priority-resolved one-hot of HSEL on every HCLK edge where HREADY=1; the lowest set index SHALL win.
REQ-004 The select register SHALL hold its value while HREADY=0.
REQ-005 While the select register is one-hot on slave i, HRDATA, HREADY and HRESP SHALL equal slave i's HRDATA_S slice, HREADYOUT_S[i] and HRESP_S[i], combinationally, with zero added latency.
REQ-006 While the select register is all-zero, the internal default slave SHALL drive the outputs, and HRDATA SHALL be 0.
REQ-007 Default-slave FSM states SHALL be IDLE, ERR1 and ERR2:
- IDLE: HREADY=1, HRESP=0.
- ERR1: HREADY=0, HRESP=1.
- ERR2: HREADY=1, HRESP=1.
REQ-008 IDLE->ERR1 SHALL occur when HREADY=1, HSEL=0 and HTRANS[1]=1 (NONSEQ/SEQ); with HTRANS IDLE/BUSY and HSEL=0, the FSM SHALL stay in IDLE, giving a zero-wait OKAY.
REQ-009 ERR1->ERR2 SHALL occur unconditionally; HTRANS changes during ERR1 SHALL be ignored.
REQ-010 From ERR2, the FSM SHALL return to IDLE, except that it SHALL go to ERR1 if a new unmapped NONSEQ/SEQ is sampled in that cycle, giving back-to-back errors.
REQ-011 Back-to-back transfers to different slaves SHALL switch the data-phase source exactly one cycle after the address phase, with no bubble.

Reset
REQ-012 While HRESETn=0 at an HCLK edge, the select register SHALL clear to 0, the FSM SHALL go to IDLE and the watchdog counter SHALL clear to 0, so that from the following cycle HRDATA=0, HREADY=1 and HRESP=0.
REQ-013 A reset asserted during ERR1 or ERR2 SHALL abandon the error response; the first cycle after release SHALL be IDLE/OKAY.

Configuration
REQ-014 With AHB_MUX_TIMEOUT_EN defined, the watchdog SHALL behave as follows:
- A counter SHALL increment each cycle a real slave is selected with HREADYOUT_S low.
- The counter SHALL clear when that slave's HREADYOUT_S goes high.
- On reaching TMO_CYCLES, the mux SHALL clear the select register, enter ERR1 and complete the two-cycle ERROR itself.
- The slave's later outputs SHALL be ignored until a new address phase.
REQ-015 Without AHB_MUX_TIMEOUT_EN, no counter logic SHALL exist, and a slave holding HREADYOUT_S low SHALL stall the bus indefinitely.

Structure
REQ-016 Package ahb_pkg SHALL hold:
- the HTRANS encodings: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- the HRESP encodings: OKAY=0, ERROR=1.
- the default-slave state enum.
REQ-017 The default slave FSM SHALL be the sub-module ahb_default_slave, which has no other sub-modules.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- NSLAVE=4, HSEL=0010, NONSEQ, slave1 HRDATA_S=0xCAFEF00D, ready=1 -> next cycle HRDATA=0xCAFEF00D, HREADY=1, HRESP=0.
- HSEL=0110 -> slave1 wins; slave2 data never appears.
- HSEL=0000, NONSEQ -> HREADY/HRESP sequence (0,1) then (1,1), HRDATA=0; a second unmapped NONSEQ sampled in ERR2 -> the (0,1),(1,1) sequence repeats immediately.
- Slave0 holds HREADYOUT_S low for 3 cycles while HSEL changes to 0100 -> the select register stays on slave0 until HREADY=1, then slave2 data appears.
- Reset pulsed during ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0.
- With AHB_MUX_TIMEOUT_EN and TMO_CYCLES=8, slave3 held not-ready -> after 8 stall cycles, a two-cycle ERROR completes; without the macro the stall persists for 100 or more cycles.
